// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a back-to-back LSB-first serialiser.
// Optional even-parity bit (8E1) compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          tx_data,
  input  logic                tx_valid,
  output logic                tx_busy,
  output logic                tx_idle,
  output logic [DEPTH_LOG2:0] tx_level,
  output logic                overflow,
  output logic                txd,
  output logic [2:0]          dbg_state
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int CW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  // Write side handshake: a byte is taken when tx_valid is high and tx_busy is low;
  // a tx_valid while tx_busy is high is dropped and latches overflow.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [2:0]            r_bit, w_bit_nxt;
  logic [7:0]            r_shift, w_shift_nxt;
  logic                  r_txd, w_txd_nxt;
  logic                  w_pop, w_push, w_empty, w_cnt_end;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_ovf;
`ifdef UART_TX_PARITY_EN
  logic                  r_par;
`endif

  assign tx_busy   = (r_level == LVL_FULL);
  assign tx_level  = r_level;
  assign overflow  = r_ovf;
  assign txd       = r_txd;
  assign dbg_state = r_state;
  assign w_empty   = (r_level == '0);
  assign tx_idle   = w_empty && (r_state == S_IDLE);
  assign w_push    = tx_valid && !tx_busy;
  assign w_cnt_end = (r_cnt == CNT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_state_nxt = S_START;
        end
      end
      S_START: if (w_cnt_end) begin
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = S_DATA;
      end
      S_DATA: if (w_cnt_end) begin
        w_cnt_nxt = '0;
        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end else begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_cnt_end) begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_STOP;
      end
`endif
      S_STOP: if (w_cnt_end) begin
        w_cnt_nxt = '0;
        // Chain straight into the next start bit so queued frames have no gap.
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The line level is registered from the state being entered, so txd changes on the same edge.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_txd_nxt = r_par;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured at pop time because the shift register is consumed during DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_par <= 1'b0;
    else if (w_pop) r_par <= ^r_mem[r_rd_ptr];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (tx_valid && tx_busy) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a frame-schedule model predicts txd, level,
// busy, idle and overflow every cycle.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   tx_data = 8'h00;
  logic         tx_valid = 1'b0;
  logic         tx_busy, tx_idle, overflow, txd;
  logic [DL2:0] tx_level;
  logic [2:0]   dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_busy(tx_busy), .tx_idle(tx_idle), .tx_level(tx_level),
    .overflow(overflow), .txd(txd), .dbg_state(dbg_state)
  );

  // scoreboard / reference model
  logic [7:0] exp_q[$];
  int         cyc = 0;
  bit         in_frame = 0;
  int         f_start = 0;
  logic [7:0] cur = 8'h00;
  bit         m_ovf = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         peak_lvl = 0;
  bit         busy_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_txd();
    int off, b;
    if (!in_frame) return 1'b1;
    off = cyc - f_start;
    b   = off / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^cur;
`endif
    return 1'b1;
  endfunction

  task automatic compare_all();
    check("txd", txd, exp_txd());
    check("level", tx_level, exp_q.size());
    check("busy", tx_busy, exp_q.size() == DEPTH);
    check("idle", tx_idle, !in_frame && exp_q.size() == 0);
    check("ovf", overflow, m_ovf);
    if (int'(tx_level) > peak_lvl) peak_lvl = int'(tx_level);
    if (tx_busy) busy_seen = 1;
  endtask

  // driver: one clock cycle with optional write, model update, then check
  task automatic step(input bit v, input logic [7:0] d);
    bit acc;
    tx_valid = v;
    tx_data  = d;
    @(posedge clk);
    cyc++;
    acc = v && (exp_q.size() < DEPTH);
    if (v && !acc) m_ovf = 1;
    if (in_frame && (cyc - f_start == FRAME)) begin
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        f_start = cyc;
      end else begin
        in_frame = 0;
      end
    end else if (!in_frame && exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      f_start = cyc;
      in_frame = 1;
    end
    if (acc) exp_q.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
    compare_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Asserted away from the clock edge so the asynchronous effect is observable.
  task automatic do_reset();
    tx_valid = 1'b0;
    rst = 1'b1;
    #1;
    exp_q.delete();
    in_frame = 0;
    m_ovf = 0;
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_state", dbg_state, 3'd0);

    // single byte 0x55
    step(1'b1, 8'h55);
    check("txd_before_fall", txd, 1'b1);
    step(1'b0, 8'h00);
    check("txd_fall", txd, 1'b0);
    idle_steps(FRAME + 4);
    check("idle_after_frame", tx_idle, 1'b1);

    // four consecutive writes
    peak_lvl = 0;
    busy_seen = 0;
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i));
    idle_steps(4 * FRAME + 4);
    check("burst_peak", peak_lvl, 3);
    check("burst_busy", busy_seen, 1'b0);
    check("burst_ovf", overflow, 1'b0);

    // fill while mid-frame, then an overflowing write
    step(1'b1, 8'h11);
    idle_steps(5);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h21 + 8'(i));
    check("full_busy", tx_busy, 1'b1);
    step(1'b1, 8'hAA);
    check("ovf_set", overflow, 1'b1);
    idle_steps(5 * FRAME + 4);

    // write on the same edge as the stop-end pop
    do_reset();
    step(1'b1, 8'hC3);
    step(1'b1, 8'h5A);
    step(1'b1, 8'h96);
    while (cyc + 1 - f_start != FRAME) step(1'b0, 8'h00);
    step(1'b1, 8'h3C);
    check("lvl_pop_wr", tx_level, 2);
    idle_steps(4 * FRAME + 4);

    // reset during data bit 3 of 0x0F
    do_reset();
    step(1'b1, 8'h0F);
    step(1'b1, 8'h33);
    while (cyc - f_start < 4 * CPB + 1) step(1'b0, 8'h00);
    do_reset();
    check("rst_mid_txd", txd, 1'b1);
    check("rst_mid_lvl", tx_level, 0);
    idle_steps(FRAME + 4);

    // randomised bursts
    for (int p = 0; p < 15; p++) begin
      int thr;
      thr = $urandom_range(0, 10);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 9) < thr, 8'($urandom_range(0, 255)));
    end
    idle_steps(5 * FRAME + 4);

    // reset during a start bit: line must return high at once
    step(1'b1, 8'h00);
    idle_steps(2);
    check("start_low", txd, 1'b0);
    do_reset();
    idle_steps(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter that serves the execute stage's output path. The execute stage presents a byte with a one-cycle strobe and stalls while `tx_busy` is high. The block queues bytes in a small FIFO and serialises them LSB-first on `txd`, back-to-back with no idle bit between frames. It replaces the unbuffered transmitter so that short output bursts do not stall the pipeline.

## Interface
- `CLK_PER_BIT`, 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 2.
- `DEPTH_LOG2`, 4, log2 of FIFO depth (16 entries).

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_data`  in  8  byte to send; sampled only when the write is accepted.
- `tx_valid`  in  1  one-cycle write strobe.
- `tx_busy`  out  1  FIFO full; a write in this cycle is not accepted.
- `tx_idle`  out  1  FIFO empty and serialiser in IDLE.
- `tx_level`  out  DEPTH_LOG2+1  FIFO occupancy, 0..2^DEPTH_LOG2.
- `overflow`  out  1  sticky; set when `tx_valid` is asserted while `tx_busy` is high.
- `txd`  out  1  serial line, idle high, registered.

## Operation
- **Write acceptance**
  - A write is accepted when `tx_valid` is high and `tx_busy` is low.
  - The byte is stored at the write pointer and `tx_level` is incremented.
  - A write attempted while full is dropped, `overflow` is set to 1, and FIFO contents are unchanged.
- **FIFO**
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap modulo depth.
  - `tx_busy = (tx_level == 2^DEPTH_LOG2)`.
  - Simultaneous accepted write and pop: `tx_level` is unchanged and both pointers advance.
- **Serialiser FSM states:** IDLE, START, DATA, [PARITY], STOP.
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter and go to START.
  - START: `txd`=0 for CLK_PER_BIT cycles, then DATA.
  - DATA: `txd`=shift[0]; every CLK_PER_BIT cycles shift right and increment the 3-bit bit counter. After bit 7, go to PARITY if enabled, otherwise STOP.
  - PARITY: `txd` = XOR of the 8 data bits (even parity) for CLK_PER_BIT cycles.
  - STOP: `txd`=1 for CLK_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go to START directly; otherwise go to IDLE.
- **Baud counter:** counts 0..CLK_PER_BIT-1 and is cleared on every state transition; width is $clog2(CLK_PER_BIT).
- **`tx_idle`:** low from the cycle after any accepted write until the final STOP bit completes with the FIFO empty.
- **Reset:**
  - FIFO is emptied, pointers are cleared and the FSM returns to IDLE.
  - Reset values: `txd`=1, `tx_busy`=0, `tx_idle`=1, `tx_level`=0, `overflow`=0.
  - Reset mid-frame drives `txd` high immediately (asynchronous) and abandons the partial frame; no resumption after reset is released.

## Timing
- Write accepted at edge N into an empty FIFO with the FSM in IDLE:
  - `tx_level`=1 after edge N.
  - Pop and START entry occur at edge N+1, so `txd` falls after edge N+1.
  - `tx_level` returns to 0 after edge N+1.
- Frame length is exactly 10·CLK_PER_BIT cycles, or 11·CLK_PER_BIT with parity.
- Consecutive queued bytes: the next start bit begins on the edge that ends the previous stop bit, with zero gap.
- `tx_busy` is a combinational decode of the registered `tx_level`. A producer that sees `tx_busy`=0 in cycle N may write in cycle N.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and every frame carries an even-parity bit between data bit 7 and STOP (8E1).
- `UART_TX_PARITY_EN` undefined: the PARITY state and its logic are absent and frames are 8N1.

## Test plan
All scenarios use CLK_PER_BIT=4 and DEPTH_LOG2=2.
- Single byte 0x55 written to an idle block:
  - `txd` falls one cycle after the write.
  - Line sequence over 40 cycles: 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles.
  - `tx_idle` returns to 1 after the stop bit.
- Bytes 0x01,0x02,0x03,0x04 on consecutive cycles:
  - `tx_level` peaks at 3 (one byte is already popped).
  - `tx_busy` never asserts and `overflow`=0.
  - Four frames are sent with no idle cycles between them.
- Fill to 4 while the FSM is mid-frame, then write 0xAA with `tx_busy`=1:
  - `overflow`=1 and 0xAA is never transmitted.
  - The 4 queued bytes go out in order.
- Write at the same edge the STOP-end pop occurs, with `tx_level`=2: `tx_level` stays 2 and the next frame starts with zero gap.
- Assert `rst` during data bit 3 of 0x0F:
  - `txd`=1 immediately and `tx_level`=0.
  - No further edges on `txd` after release.
- Byte 0x07 with `UART_TX_PARITY_EN` defined:
  - Parity bit = 1.
  - Frame is 44 cycles; the stop bit begins at cycle 40.
